// File: rtl/serv_mem_arbiter.sv
// Three-way Wishbone-classic arbiter (ibus, dbus, external master) onto one memory port.
// Define SERV_MEM_ARBITER_TIMEOUT_EN to build in the bus-timeout watchdog.
module serv_mem_arbiter #(
  parameter              RESET_STRATEGY = "MINI",
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_ibus_adr,
  input  logic        i_ibus_cyc,
  output logic [31:0] o_ibus_rdt,
  output logic        o_ibus_ack,
  input  logic [31:0] i_dbus_adr,
  input  logic [31:0] i_dbus_dat,
  input  logic [3:0]  i_dbus_sel,
  input  logic        i_dbus_we,
  input  logic        i_dbus_cyc,
  output logic [31:0] o_dbus_rdt,
  output logic        o_dbus_ack,
  input  logic [31:0] i_ext_adr,
  input  logic [31:0] i_ext_dat,
  input  logic [3:0]  i_ext_sel,
  input  logic        i_ext_we,
  input  logic        i_ext_cyc,
  output logic [31:0] o_ext_rdt,
  output logic        o_ext_ack,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("serv_mem_arbiter: STARVE_LIMIT must be 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("serv_mem_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    GNT_X = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       real_ack;
  logic       to_hit;
  logic       force_ack;
  logic       ack_any;
  logic [31:0] rdt;

  assign o_grant = state;

  // Memory-side request mux; the granted master's cyc is passed straight through.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_adr = '0;
    o_wb_dat = '0;
    o_wb_sel = '0;
    o_wb_we  = 1'b0;
    case (state)
      GNT_I: begin
        o_wb_cyc = i_ibus_cyc;
        o_wb_adr = i_ibus_adr;
        o_wb_sel = '1;
      end
      GNT_D: begin
        o_wb_cyc = i_dbus_cyc;
        o_wb_adr = i_dbus_adr;
        o_wb_dat = i_dbus_dat;
        o_wb_sel = i_dbus_sel;
        o_wb_we  = i_dbus_we;
      end
      GNT_X: begin
        o_wb_cyc = i_ext_cyc;
        o_wb_adr = i_ext_adr;
        o_wb_dat = i_ext_dat;
        o_wb_sel = i_ext_sel;
        o_wb_we  = i_ext_we;
      end
      default: ;
    endcase
  end

  assign real_ack  = i_wb_ack & o_wb_cyc;
  assign force_ack = to_hit & o_wb_cyc;
  assign ack_any   = real_ack | force_ack;
  assign rdt       = force_ack ? '0 : i_wb_rdt;

  assign o_ibus_rdt = rdt;
  assign o_dbus_rdt = rdt;
  assign o_ext_rdt  = rdt;
  assign o_ibus_ack = ack_any & (state == GNT_I);
  assign o_dbus_ack = ack_any & (state == GNT_D);
  assign o_ext_ack  = ack_any & (state == GNT_X);

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      IDLE: begin
        if (i_ext_cyc && (starve_cnt == STARVE_LIM)) state_nxt = GNT_X;
        else if (i_dbus_cyc)                         state_nxt = GNT_D;
        else if (i_ibus_cyc)                         state_nxt = GNT_I;
        else if (i_ext_cyc)                          state_nxt = GNT_X;
        // Counts core grants handed out while ext waits; any ext grant or idle ext resets it.
        if (!i_ext_cyc || (state_nxt == GNT_X))
          starve_nxt = '0;
        else if ((state_nxt != IDLE) && (starve_cnt < STARVE_LIM))
          starve_nxt = starve_cnt + 4'd1;
      end
      GNT_X: begin
        if (!i_ext_cyc || ack_any || to_hit) state_nxt = IDLE;
      end
      default: begin
        if (ack_any || to_hit) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    state      <= state_nxt;
    starve_cnt <= starve_nxt;
    if (i_rst) begin
      state <= IDLE;
      if (RESET_STRATEGY != "NONE") starve_cnt <= '0;
    end
  end

`ifdef SERV_MEM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] to_cnt;

  // A real ack on the expiry cycle completes normally and does not set the flag.
  assign to_hit = (state != IDLE) & (to_cnt == TO_LAST) & ~real_ack;

  always_ff @(posedge i_clk) begin
    if (state == IDLE)
      to_cnt <= '0;
    else if (!i_wb_ack)
      to_cnt <= to_cnt + 16'd1;
    if (to_hit)
      o_timeout <= 1'b1;
    if (i_rst) begin
      o_timeout <= 1'b0;
      if (RESET_STRATEGY != "NONE") to_cnt <= '0;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_serv_mem_arbiter.sv
// Directed bench for serv_mem_arbiter: a per-cycle reference model plus literal spot checks.
// Build with SERV_MEM_ARBITER_TIMEOUT_EN to exercise the watchdog expectations.
module tb_serv_mem_arbiter;
  localparam int SL = 4;
  localparam int TC = 8;
`ifdef SERV_MEM_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr, i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we, i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] i_ext_adr, i_ext_dat;
  logic [3:0]  i_ext_sel;
  logic        i_ext_we, i_ext_cyc;
  logic [31:0] o_ext_rdt;
  logic        o_ext_ack;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic [1:0]  o_grant;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  serv_mem_arbiter #(
    .RESET_STRATEGY ("MINI"),
    .STARVE_LIMIT   (SL),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .i_ext_adr  (i_ext_adr),
    .i_ext_dat  (i_ext_dat),
    .i_ext_sel  (i_ext_sel),
    .i_ext_we   (i_ext_we),
    .i_ext_cyc  (i_ext_cyc),
    .o_ext_rdt  (o_ext_rdt),
    .o_ext_ack  (o_ext_ack),
    .o_wb_adr   (o_wb_adr),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_cyc   (o_wb_cyc),
    .i_wb_rdt   (i_wb_rdt),
    .i_wb_ack   (i_wb_ack),
    .o_grant    (o_grant),
    .o_timeout  (o_timeout)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus (0 none, 1 ibus, 2 dbus, 3 ext), how many
  // core grants ext has sat through, and how long the current owner has waited.
  int owner = 0;
  int starve = 0;
  int age = 0;
  bit flag = 1'b0;
  bit live = 1'b0;

  function automatic bit owner_cyc();
    case (owner)
      1:       return i_ibus_cyc;
      2:       return i_dbus_cyc;
      3:       return i_ext_cyc;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit expired();
    return TO_EN && (owner != 0) && (age == TC - 1) && !(i_wb_ack && owner_cyc());
  endfunction

  always @(posedge i_clk) begin
    bit c, hit;
    int pick;
    c   = owner_cyc();
    hit = expired();
    if (i_rst) begin
      owner = 0; starve = 0; age = 0; flag = 1'b0;
    end else if (owner == 0) begin
      if (i_ext_cyc && starve == SL) pick = 3;
      else if (i_dbus_cyc)           pick = 2;
      else if (i_ibus_cyc)           pick = 1;
      else if (i_ext_cyc)            pick = 3;
      else                           pick = 0;
      if (!i_ext_cyc || pick == 3) starve = 0;
      else if (pick != 0 && starve < SL) starve = starve + 1;
      owner = pick;
      age = 0;
    end else begin
      if (hit) flag = 1'b1;
      if ((c && i_wb_ack) || hit || (owner == 3 && !i_ext_cyc)) owner = 0;
      if (!i_wb_ack) age = age + 1;
    end
    live = 1'b1;
  end

  always @(negedge i_clk) begin
    bit c, f, a;
    logic [31:0] e_adr, e_dat, e_rdt;
    logic [3:0]  e_sel;
    logic        e_we;
    if (live) begin
      c = owner_cyc();
      f = expired() && c;
      a = c && (i_wb_ack || f);
      e_rdt = f ? 32'h0 : i_wb_rdt;
      e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0; e_we = 1'b0;
      case (owner)
        1: begin e_adr = i_ibus_adr; e_sel = 4'hf; end
        2: begin e_adr = i_dbus_adr; e_dat = i_dbus_dat; e_sel = i_dbus_sel; e_we = i_dbus_we; end
        3: begin e_adr = i_ext_adr;  e_dat = i_ext_dat;  e_sel = i_ext_sel;  e_we = i_ext_we;  end
        default: ;
      endcase
      chk("grant",    32'(o_grant),    32'(owner));
      chk("wb_cyc",   32'(o_wb_cyc),   32'(c));
      chk("wb_adr",   o_wb_adr,        e_adr);
      chk("wb_dat",   o_wb_dat,        e_dat);
      chk("wb_sel",   32'(o_wb_sel),   32'(e_sel));
      chk("wb_we",    32'(o_wb_we),    32'(e_we));
      chk("ibus_ack", 32'(o_ibus_ack), 32'(a && owner == 1));
      chk("dbus_ack", 32'(o_dbus_ack), 32'(a && owner == 2));
      chk("ext_ack",  32'(o_ext_ack),  32'(a && owner == 3));
      chk("ibus_rdt", o_ibus_rdt,      e_rdt);
      chk("dbus_rdt", o_dbus_rdt,      e_rdt);
      chk("ext_rdt",  o_ext_rdt,       e_rdt);
      chk("timeout",  32'(o_timeout),  32'(flag));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge i_clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g[10];
    int n;
    int exp_g[10] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3};
    i_rst = 1'b1;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_ext_adr  = '0; i_ext_dat  = '0; i_ext_sel  = '0; i_ext_we  = 1'b0; i_ext_cyc  = 1'b0;
    i_wb_rdt = '0; i_wb_ack = 1'b0;

    repeat (2) tick();
    at_neg();
    chk("rst_grant",   32'(o_grant),   32'd0);
    chk("rst_wb_cyc",  32'(o_wb_cyc),  32'd0);
    chk("rst_acks",    32'({o_ibus_ack, o_dbus_ack, o_ext_ack}), 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    tick(); i_rst = 1'b0;
    tick();

    // ibus read alone: grant next cycle, ack two cycles after request
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h0000_0100;
    at_neg(); chk("t1_cyc_c0", 32'(o_wb_cyc), 32'd0);
    tick(); at_neg();
    chk("t1_grant_c1", 32'(o_grant), 32'd1);
    chk("t1_sel_c1",   32'(o_wb_sel), 32'hf);
    tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0013;
    at_neg();
    chk("t1_ack_c2", 32'(o_ibus_ack), 32'd1);
    chk("t1_rdt_c2", o_ibus_rdt, 32'h0000_0013);
    tick(); i_ibus_cyc = 1'b0; i_wb_ack = 1'b0;
    at_neg(); chk("t1_idle_c3", 32'(o_grant), 32'd0);

    // ibus and dbus together: dbus first, ibus after one idle bubble
    tick();
    i_ibus_cyc = 1'b1; i_ibus_adr = 32'h0000_0104;
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0000_0200; i_dbus_dat = 32'hcafe_f00d;
    i_dbus_sel = 4'b0011; i_dbus_we = 1'b1;
    tick(); at_neg();
    chk("t2_grant_d", 32'(o_grant), 32'd2);
    chk("t2_dat",     o_wb_dat,     32'hcafe_f00d);
    tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h0;
    at_neg();
    chk("t2_dack", 32'(o_dbus_ack), 32'd1);
    chk("t2_iack", 32'(o_ibus_ack), 32'd0);
    tick(); i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; i_wb_ack = 1'b0;
    at_neg(); chk("t2_bubble", 32'(o_grant), 32'd0);
    tick(); at_neg(); chk("t2_grant_i", 32'(o_grant), 32'd1);
    tick(); i_wb_ack = 1'b1; i_wb_rdt = 32'h1234_5678;
    at_neg(); chk("t2_iack2", 32'(o_ibus_ack), 32'd1);
    tick(); i_ibus_cyc = 1'b0; i_wb_ack = 1'b0;

    // ext and ibus always pending: ext wins every fifth grant
    tick();
    i_ibus_cyc = 1'b1; i_ext_cyc = 1'b1; i_ext_adr = 32'h0000_0300; i_ext_sel = 4'hf;
    n = 0;
    for (int k = 0; k < 60 && n < 10; k++) begin
      tick();
      i_wb_ack = (o_grant != 2'd0);
      i_wb_rdt = 32'(k);
      if (o_grant != 2'd0) begin
        g[n] = int'(o_grant);
        n++;
      end
    end
    chk("t3_grants_seen", 32'(n), 32'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("t3_seq%0d", k), 32'(g[k]), 32'(exp_g[k]));
    tick(); i_ibus_cyc = 1'b0; i_ext_cyc = 1'b0; i_wb_ack = 1'b0;

    // ext drops cyc mid-grant while memory acks: no ack, straight back to idle
    tick();
    i_ext_cyc = 1'b1; i_ext_adr = 32'h0000_0400; i_ext_we = 1'b0;
    tick(); at_neg();
    chk("t4_grant_x", 32'(o_grant), 32'd3);
    chk("t4_adr",     o_wb_adr,     32'h0000_0400);
    tick(); i_ext_cyc = 1'b0; i_wb_ack = 1'b1; i_wb_rdt = 32'hdead_beef;
    at_neg();
    chk("t4_cyc_low", 32'(o_wb_cyc),  32'd0);
    chk("t4_no_ack",  32'(o_ext_ack), 32'd0);
    tick(); i_wb_ack = 1'b0;
    at_neg(); chk("t4_idle", 32'(o_grant), 32'd0);

    // reset during a dbus grant
    tick();
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0000_0500; i_dbus_sel = 4'hf;
    tick(); at_neg(); chk("t6_grant_d", 32'(o_grant), 32'd2);
    tick(); i_rst = 1'b1;
    at_neg(); chk("t6_cyc_before", 32'(o_wb_cyc), 32'd1);
    tick(); at_neg();
    chk("t6_grant", 32'(o_grant),  32'd0);
    chk("t6_cyc",   32'(o_wb_cyc), 32'd0);
    chk("t6_acks",  32'({o_ibus_ack, o_dbus_ack, o_ext_ack}), 32'd0);
    tick(); i_rst = 1'b0; i_dbus_cyc = 1'b0;

    // real ack on the last allowed cycle completes normally
    tick();
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0000_0600; i_wb_rdt = 32'h5555_aaaa;
    repeat (TC) tick();
    i_wb_ack = 1'b1;
    at_neg();
    chk("t5a_ack", 32'(o_dbus_ack), 32'd1);
    chk("t5a_rdt", o_dbus_rdt,      32'h5555_aaaa);
    tick(); i_dbus_cyc = 1'b0; i_wb_ack = 1'b0;
    at_neg(); chk("t5a_no_flag", 32'(o_timeout), 32'd0);

    // silent slave
    tick();
    i_dbus_cyc = 1'b1; i_dbus_adr = 32'h0000_0700; i_wb_rdt = 32'hffff_ffff;
    repeat (TC - 1) tick();
    at_neg(); chk("t5_c7_no_ack", 32'(o_dbus_ack), 32'd0);
    tick(); at_neg();
`ifdef SERV_MEM_ARBITER_TIMEOUT_EN
    chk("t5_forced_ack", 32'(o_dbus_ack), 32'd1);
    chk("t5_forced_rdt", o_dbus_rdt,      32'h0);
    tick(); at_neg();
    chk("t5_flag",  32'(o_timeout), 32'd1);
    chk("t5_idle",  32'(o_grant),   32'd0);
    tick(); i_dbus_cyc = 1'b0;
`else
    chk("t5_hung_ack", 32'(o_dbus_ack), 32'd0);
    repeat (4) tick();
    at_neg();
    chk("t5_hung_grant", 32'(o_grant),   32'd2);
    chk("t5_no_flag",    32'(o_timeout), 32'd0);
    tick(); i_wb_ack = 1'b1;
    at_neg(); chk("t5_late_ack", 32'(o_dbus_ack), 32'd1);
    tick(); i_dbus_cyc = 1'b0; i_wb_ack = 1'b0;
`endif
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
